// File: rtl/arb_pkg.sv
// Shared types and sizes for the 16-way round-robin arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package arb_pkg;

  localparam int N_REQ = 16;
  localparam int IDX_W = 4;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg

// File: rtl/decoder_4_to_16.sv
// 4-bit index to 16-bit one-hot decoder with enable; all-zero when disabled.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   ena - output enable; when low the output is all zero
//   in  - binary index 0..15
//   out - one-hot vector, bit 'in' set when enabled
module decoder_4_to_16 (
  input  logic        ena,
  input  logic [3:0]  in,
  output logic [15:0] out
);

  always_comb begin
    out = 16'h0000;
    if (ena) begin
      out = 16'h0001 << in;
    end
  end

endmodule : decoder_4_to_16

// File: rtl/rr_arbiter_16.sv
// Round-robin arbiter: one shared resource, 16 requesters, bounded hold time.
// Latency: request sampled in IDLE at edge N -> grant valid after edge N; >=1 idle cycle between grants.
// Backpressure: holder keeps the grant until done, request drop, hold budget or ena low releases it.
//
// Ports:
//   clk       - single clock, rising edge
//   rst_n     - asynchronous active-low reset
//   ena       - arbiter enable; low blocks new grants and releases the active one
//   req       - request vector, bit i belongs to requester i
//   done      - current holder finished; only looked at while granting
//   grant     - one-hot grant, all-zero when idle (decoded from flops only)
//   grant_idx - index of the current or most recent winner
//   busy      - a grant is active
module rr_arbiter_16
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic [N_REQ-1:0]   req,
  input  logic               done,
  output logic [N_REQ-1:0]   grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               busy
);

  // Wide enough to hold MAX_HOLD itself so the saturation value is representable.
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_LAST = HC_W'(MAX_HOLD - 1);
  localparam logic [HC_W-1:0] HOLD_SAT  = HC_W'(MAX_HOLD);

  arb_state_t        state_q, state_d;
  logic [IDX_W-1:0]  ptr_q, ptr_d;
  logic [IDX_W-1:0]  grant_idx_q, grant_idx_d;
  logic [HC_W-1:0]   hold_cnt_q, hold_cnt_d;

  // Rotating priority search result.
  logic              found;
  logic [IDX_W-1:0]  pick;

  logic              release_now;

  // Walk the 16 offsets starting at ptr; the first set request wins.
  // Index addition is 4 bits wide so the walk wraps 15 -> 0 on its own.
  always_comb begin
    found = 1'b0;
    pick  = ptr_q;
    for (int k = 0; k < N_REQ; k++) begin
      logic [IDX_W-1:0] cand;
      cand = ptr_q + IDX_W'(k);
      if (!found && req[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  // Any number of causes collapse into one release event, so ptr moves once.
  always_comb begin
    release_now = done
               || !req[grant_idx_q]
               || (hold_cnt_q == HOLD_LAST)
               || !ena;
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_idx_d = grant_idx_q;
    hold_cnt_d  = hold_cnt_q;

    unique case (state_q)
      IDLE: begin
        // done is deliberately not looked at here.
        if (ena && found) begin
          state_d     = GRANT;
          grant_idx_d = pick;
          hold_cnt_d  = '0;
        end
      end

      GRANT: begin
        if (hold_cnt_q != HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HC_W'(1);
        end
        if (release_now) begin
          state_d = IDLE;
          // Winner drops to lowest priority; grant_idx keeps reporting it.
          ptr_d   = grant_idx_q + IDX_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      grant_idx_q <= '0;
      hold_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_idx_q <= grant_idx_d;
      hold_cnt_q  <= hold_cnt_d;
    end
  end

  // Outputs depend on flops only, so reset clears them without a clock.
  decoder_4_to_16 u_grant_dec (
    .ena (state_q == GRANT),
    .in  (grant_idx_q),
    .out (grant)
  );

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == GRANT);

endmodule : rr_arbiter_16

// File: tb/tb_rr_arbiter_16.sv
module tb_rr_arbiter_16;
  import arb_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              ena;
  logic [15:0]       req;
  logic              done;
  logic [15:0]       grant;
  logic [3:0]        grant_idx;
  logic              busy;

  int n_tests;
  int n_fail;

  typedef struct {
    logic [15:0] req;
    logic        ena;
    logic        done;
    logic [15:0] exp_grant;
    logic [3:0]  exp_idx;
    logic        exp_busy;
  } vec_t;

  localparam int NVEC = 24;
  vec_t vec [NVEC];

  rr_arbiter_16 #(.MAX_HOLD(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .req       (req),
    .done      (done),
    .grant     (grant),
    .grant_idx (grant_idx),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic chk_out(input string tag, input logic [15:0] eg, input logic [3:0] ei, input logic eb);
    chk({tag, ".grant"}, {16'h0, grant}, {16'h0, eg});
    chk({tag, ".idx"},   {28'h0, grant_idx}, {28'h0, ei});
    chk({tag, ".busy"},  {31'h0, busy}, {31'h0, eb});
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;

    // Continuous sequence from reset: ptr=0, idx=0 at the start.
    //               req       ena   done  grant     idx    busy
    vec[0]  = '{16'h0008, 1'b1, 1'b0, 16'h0008, 4'd3,  1'b1}; // single requester
    vec[1]  = '{16'h0008, 1'b1, 1'b1, 16'h0000, 4'd3,  1'b0}; // done -> ptr=4
    vec[2]  = '{16'h0008, 1'b1, 1'b0, 16'h0008, 4'd3,  1'b1}; // re-grant after bubble
    vec[3]  = '{16'h0008, 1'b1, 1'b1, 16'h0000, 4'd3,  1'b0}; // ptr=4
    vec[4]  = '{16'h8001, 1'b1, 1'b0, 16'h8000, 4'd15, 1'b1}; // from 4: 15 first
    vec[5]  = '{16'h8001, 1'b1, 1'b1, 16'h0000, 4'd15, 1'b0}; // ptr wraps to 0
    vec[6]  = '{16'h8001, 1'b1, 1'b0, 16'h0001, 4'd0,  1'b1};
    vec[7]  = '{16'h8001, 1'b1, 1'b1, 16'h0000, 4'd0,  1'b0}; // ptr=1
    vec[8]  = '{16'h8001, 1'b1, 1'b0, 16'h8000, 4'd15, 1'b1};
    vec[9]  = '{16'h8001, 1'b1, 1'b1, 16'h0000, 4'd15, 1'b0}; // ptr=0
    vec[10] = '{16'h8001, 1'b1, 1'b0, 16'h0001, 4'd0,  1'b1};
    vec[11] = '{16'h8001, 1'b1, 1'b1, 16'h0000, 4'd0,  1'b0}; // ptr=1
    vec[12] = '{16'h8001, 1'b1, 1'b0, 16'h8000, 4'd15, 1'b1};
    vec[13] = '{16'h8002, 1'b1, 1'b0, 16'h8000, 4'd15, 1'b1}; // other bits ignored
    vec[14] = '{16'h0002, 1'b1, 1'b0, 16'h0000, 4'd15, 1'b0}; // req[15] drop -> ptr=0
    vec[15] = '{16'h0002, 1'b1, 1'b0, 16'h0002, 4'd1,  1'b1};
    vec[16] = '{16'h0002, 1'b0, 1'b0, 16'h0000, 4'd1,  1'b0}; // ena low releases, ptr=2
    vec[17] = '{16'h0002, 1'b0, 1'b0, 16'h0000, 4'd1,  1'b0}; // no grant while disabled
    vec[18] = '{16'h0002, 1'b0, 1'b0, 16'h0000, 4'd1,  1'b0};
    vec[19] = '{16'h0002, 1'b1, 1'b0, 16'h0002, 4'd1,  1'b1}; // search wraps to 1
    vec[20] = '{16'h0002, 1'b1, 1'b1, 16'h0000, 4'd1,  1'b0}; // ptr=2
    vec[21] = '{16'h0002, 1'b1, 1'b1, 16'h0002, 4'd1,  1'b1}; // done ignored in IDLE
    vec[22] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1,  1'b0}; // req drop, ptr=2
    vec[23] = '{16'h0000, 1'b1, 1'b0, 16'h0000, 4'd1,  1'b0};

    // Reset and idle.
    rst_n = 1'b0;
    ena   = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    #2;
    chk_out("reset", 16'h0000, 4'd0, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;
    ena   = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk({"idle", ".grant"}, {16'h0, grant}, 32'h0);
      chk({"idle", ".busy"},  {31'h0, busy}, 32'h0);
    end
    chk("idle.idx", {28'h0, grant_idx}, 32'h0);

    // Table-driven section.
    for (int i = 0; i < NVEC; i++) begin
      req  = vec[i].req;
      ena  = vec[i].ena;
      done = vec[i].done;
      tick();
      chk_out($sformatf("vec%0d", i), vec[i].exp_grant, vec[i].exp_idx, vec[i].exp_busy);
    end

    // Timeout: lone requester 5, ptr=2. Grant lasts exactly 8 cycles.
    req  = 16'h0020;
    ena  = 1'b1;
    done = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk_out($sformatf("tmo_hold%0d", k), 16'h0020, 4'd5, 1'b1);
    end
    tick();
    chk_out("tmo_release", 16'h0000, 4'd5, 1'b0);  // ptr=6
    tick();
    chk_out("tmo_regrant", 16'h0020, 4'd5, 1'b1);

    // Requester 6 joins mid-grant; it takes over after the timeout.
    req = 16'h0060;
    for (int k = 2; k <= 8; k++) begin
      tick();
      chk_out($sformatf("tmo2_hold%0d", k), 16'h0020, 4'd5, 1'b1);
    end
    tick();
    chk_out("tmo2_release", 16'h0000, 4'd5, 1'b0);  // ptr=6
    tick();
    chk_out("tmo2_winner6", 16'h0040, 4'd6, 1'b1);

    // Run 7 more grant cycles, then done + req drop + timeout together.
    for (int k = 2; k <= 8; k++) begin
      tick();
    end
    chk_out("multi_pre", 16'h0040, 4'd6, 1'b1);
    done = 1'b1;
    req  = 16'h0020;
    tick();
    chk_out("multi_release", 16'h0000, 4'd6, 1'b0);
    // ptr must be 7 exactly: 6 -> 6 would win, 8 -> 6 would win, 7 -> 7 wins.
    done = 1'b0;
    req  = 16'h00C0;
    tick();
    chk_out("multi_ptr_once", 16'h0080, 4'd7, 1'b1);

    // Disable mid-grant.
    ena = 1'b0;
    tick();
    chk_out("dis_release", 16'h0000, 4'd7, 1'b0);  // ptr=8
    tick();
    tick();
    chk_out("dis_hold_off", 16'h0000, 4'd7, 1'b0);

    // Asynchronous reset mid-grant on requester 10 (ptr=8).
    ena = 1'b1;
    req = 16'h0400;
    tick();
    chk_out("ar_grant", 16'h0400, 4'd10, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    chk_out("ar_async_clear", 16'h0000, 4'd0, 1'b0);
    tick();
    rst_n = 1'b1;
    // Requesters 0 and 10: 0 wins only if ptr went back to 0.
    req = 16'h0401;
    tick();
    chk_out("ar_ptr0", 16'h0001, 4'd0, 1'b1);
    done = 1'b1;
    tick();
    chk_out("ar_done", 16'h0000, 4'd0, 1'b0);
    done = 1'b0;
    req  = 16'h0400;
    tick();
    chk_out("ar_regrant10", 16'h0400, 4'd10, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_rr_arbiter_16

// File: doc/rr_arbiter_16.md
# rr_arbiter_16

Round-robin arbiter sharing one resource among 16 requesters. Selects a winner index, holds the grant until the winner releases, drops its request or exhausts a hold budget, then rotates priority past the winner. The one-hot grant vector comes from the existing `decoder_4_to_16`, driven by the registered winner index. This is the front-end scheduler for any 16-way shared datapath.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive cycles a single grant may last.
  - Legal range 1..255.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous reset, active-low.
- `ena` in 1: arbiter enable.
  - When low, no new grant starts.
  - When low, any active grant is released.
- `req` in 16: request vector, bit i belongs to requester i.
- `done` in 1: current holder finished; release now.
- `grant` out 16: one-hot grant, all-zero when idle.
- `grant_idx` out 4: index of the current or most recent winner.
- `busy` out 1: a grant is active.

## Operation
- FSM states:
  - `IDLE`: no grant.
  - `GRANT`: `grant_idx` owns the resource.
- Priority pointer `ptr` (4 bits) marks the highest-priority requester.
  - Search order is `ptr, ptr+1, …, 15, 0, …, ptr-1`.
- `IDLE` behaviour:
  - If `ena && |req`: register the first set bit in search order into `grant_idx`, clear `hold_cnt`, and go to `GRANT`.
  - Otherwise stay in `IDLE`.
- `GRANT` behaviour:
  - `hold_cnt` increments each cycle, saturating at `MAX_HOLD`.
  - Release is triggered by any of the following, evaluated in the same cycle:
    - `done`
    - `!req[grant_idx]`
    - `hold_cnt == MAX_HOLD-1` (budget spent)
    - `!ena`
  - On release: go to `IDLE`, set `ptr <= grant_idx + 1` (mod 16, so 15 wraps to 0), and keep `grant_idx` unchanged.
- Output equations:
  - `grant` = `decoder_4_to_16(.ena(state==GRANT), .in(grant_idx))`.
  - `busy` = `(state==GRANT)`.
- Width rules:
  - `hold_cnt` width is `$clog2(MAX_HOLD+1)`.
  - Index arithmetic is 4-bit and wraps naturally.
- Reset values:
  - `state=IDLE`
  - `ptr=0`
  - `grant_idx=0`
  - `hold_cnt=0`
  - Outputs follow: `grant=16'h0000`, `busy=0`.
- Boundary cases:
  - Several release causes in one cycle count as a single release. `ptr` advances exactly once.
  - A requester whose request is still high after timeout re-enters arbitration. It now has lowest priority.
  - If only one requester is active, it is re-granted after a one-cycle bubble.
  - `req` changing while in `GRANT` has no effect except via `req[grant_idx]`.
  - `rst_n` asserted mid-grant clears `grant` immediately (asynchronous). `ptr` returns to 0.

## Timing
- Request-to-grant latency is 1 cycle. `req` sampled high at edge N in `IDLE` gives `grant` valid after edge N.
- `grant` and `busy` are decoded from flops only. There is no combinational path from `req`, `done` or `ena` to any output.
- A release condition seen at edge N deasserts `grant` after edge N.
- The next grant is sampled at edge N+1, so there is a minimum one idle cycle between grants.
- The maximum grant length is `MAX_HOLD` cycles.
- `done` is a level sampled only in `GRANT`. It is ignored in `IDLE`.

## Structure
- Shared package `arb_pkg` holds:
  - `typedef enum logic {IDLE, GRANT} arb_state_t`
  - `localparam N_REQ = 16`
  - `localparam IDX_W = 4`
- Sub-modules:
  - One sub-module: reuse `decoder_4_to_16` for the grant vector.
  - The rotating priority search is inline combinational logic (loop over 16 offsets). It is not a separate module.

## Test plan
- Reset and idle:
  - With `rst_n=0`, `grant=0`, `busy=0`, `grant_idx=0`.
  - Release reset with `req=0`: outputs stay 0 for 10 cycles.
- Single requester:
  - `req=16'h0008`, `ena=1`: next cycle `grant=16'h0008` and `grant_idx=3`.
  - Pulse `done`: next cycle `grant=0`, then `grant=16'h0008` again, with `ptr=4`.
- Rotation:
  - Hold `req=16'h8001` high with `done` pulsed each grant.
  - Grants alternate `16'h0001`, `16'h8000`, `16'h0001`, … (after index 15, `ptr` wraps to 0).
- Timeout with `MAX_HOLD=8`:
  - Hold `req[5]` high and never assert `done`.
  - Grant lasts exactly 8 cycles, then 1 idle cycle, then re-grant.
  - With `req[6]` also high, index 6 wins after the timeout.
- Simultaneous release and disable:
  - Assert `done`, drop `req[idx]` and hit timeout in the same cycle: one release, `ptr` advances by one.
  - Drop `ena` mid-grant: `grant=0` next cycle, no new grant while `ena=0`.
- Asynchronous reset mid-grant:
  - Assert `rst_n=0` between clock edges while `grant=16'h0400`: `grant` goes 0 without waiting for a clock.
  - After release with `req=16'h0400`, the first grant is `16'h0400`, searching from `ptr=0`.
